gestor_necesidades: RTL and testbench

- Supervisor FSM on the consumer side of the four need channels: Animo, Descanso, Energia and Medicina.
- Reads the four 2-bit need levels and the per-channel 5-second pulses.
- Decides which single need is being attended and drives the matching Activo_* line back into the mode block.
- Produces the pet's display state code, an alert flag, a latched death flag, and a rotating test pattern while test mode is held.

---
 rtl/gestor_necesidades.sv | 261 ++++++++++++++++++++++++++
 tb/tb_gestor_necesidades.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gestor_necesidades.sv
// gestor_necesidades: supervisor FSM for the four need channels
// (Animo, Descanso, Energia, Medicina). Picks the single need to attend,
// drives the matching Activo_* line, and reports the pet's display state,
// an alert flag, a latched death flag and a rotating test-mode pattern.
// Every output is a flop loaded from the next-state values, so outputs
// respond one clock after the inputs that caused them.
module gestor_necesidades #(
  parameter int UMBRAL   = 1,   // level <= UMBRAL marks a need as critical
  parameter int N_MUERTE = 4,   // qualifying 5 s pulses that kill the pet
  parameter int T_ROTA   = 10   // clk cycles per test-mode rotation slot
) (
  input  logic       clk,
  input  logic       B_reset,
  input  logic [1:0] Nivel_Animo,
  input  logic [1:0] Nivel_Descanso,
  input  logic [1:0] Nivel_Energia,
  input  logic [1:0] Nivel_Medicina,
  input  logic       senal_5segAnimo,
  input  logic       senal_5segDescanso,
  input  logic       senal_5segEnergia,
  input  logic       senal_5segMedicina,
  input  logic       Senal_MTest,
  output logic       Activo_Comida,
  output logic       Activo_Medicina,
  output logic       Activo_Descanso,
  output logic       Activo_Carisia,
  output logic [2:0] Estado,
  output logic       Alerta,
  output logic       Muerto
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATENDIENDO,
    ST_TEST,
    ST_MUERTO
  } state_t;

  // Need encoding doubles as the bit position in the Activo_* vector,
  // which is also the test rotation order Comida -> Medicina -> Descanso -> Carisia.
  typedef enum logic [1:0] {
    NEED_ENERGIA  = 2'd0,
    NEED_MEDICINA = 2'd1,
    NEED_DESCANSO = 2'd2,
    NEED_ANIMO    = 2'd3
  } need_t;

  typedef struct packed {
    logic  valid;
    need_t need;
  } pick_t;

  localparam logic [1:0] UMB       = 2'(UMBRAL);
  localparam int         ROT_W     = (T_ROTA > 1) ? $clog2(T_ROTA) : 1;
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(T_ROTA - 1);

  localparam logic [2:0] EST_FELIZ   = 3'd0;
  localparam logic [2:0] EST_HAMBRE  = 3'd1;
  localparam logic [2:0] EST_ENFERMO = 3'd2;
  localparam logic [2:0] EST_CANSADO = 3'd3;
  localparam logic [2:0] EST_TRISTE  = 3'd4;
  localparam logic [2:0] EST_MUERTO  = 3'd5;
  localparam logic [2:0] EST_TEST    = 3'd7;

  // Lowest critical level wins; ties go Medicina > Energia > Descanso > Animo.
  // Scanning in priority order and replacing only on a strictly lower level
  // keeps the earlier (higher-priority) channel on ties.
  function automatic pick_t select_need(input logic [3:0][1:0] lvl);
    pick_t best;
    best.valid = 1'b0;
    best.need  = NEED_MEDICINA;
    for (int k = 0; k < 4; k++) begin
      need_t cand;
      case (k)
        0:       cand = NEED_MEDICINA;
        1:       cand = NEED_ENERGIA;
        2:       cand = NEED_DESCANSO;
        default: cand = NEED_ANIMO;
      endcase
      if (lvl[cand] <= UMB && (!best.valid || lvl[cand] < lvl[best.need])) begin
        best.valid = 1'b1;
        best.need  = cand;
      end
    end
    return best;
  endfunction

  function automatic logic [2:0] estado_de(input need_t n);
    case (n)
      NEED_ENERGIA:  return EST_HAMBRE;
      NEED_MEDICINA: return EST_ENFERMO;
      NEED_DESCANSO: return EST_CANSADO;
      default:       return EST_TRISTE;
    endcase
  endfunction

  // Channel views indexed by need
  logic [3:0][1:0] nivel;
  logic [3:0]      pulso;
  logic [3:0]      cero;
  pick_t           pick;

  assign nivel[NEED_ENERGIA]  = Nivel_Energia;
  assign nivel[NEED_MEDICINA] = Nivel_Medicina;
  assign nivel[NEED_DESCANSO] = Nivel_Descanso;
  assign nivel[NEED_ANIMO]    = Nivel_Animo;

  assign pulso[NEED_ENERGIA]  = senal_5segEnergia;
  assign pulso[NEED_MEDICINA] = senal_5segMedicina;
  assign pulso[NEED_DESCANSO] = senal_5segDescanso;
  assign pulso[NEED_ANIMO]    = senal_5segAnimo;

  assign pick = select_need(nivel);

  // State, registers and their next values
  state_t           state_q, state_d;
  need_t            sel_q, sel_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [ROT_W-1:0] rot_cnt_q, rot_cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [3:0]       activo_q, activo_d;
  logic [2:0]       estado_q, estado_d;
  logic             alerta_q, alerta_d;
  logic             muerto_q, muerto_d;
  logic             hay_cero;
  logic             muerte;

  // Death counter: saturating count of cycles with a pulse from a zero-level channel
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    cero = '0;
    for (int i = 0; i < 4; i++) begin
      cero[i] = (nivel[i] == 2'd0);
    end
    hay_cero = |cero;
    cnt_d    = cnt_q;
    if (!hay_cero) begin
      cnt_d = 3'd0;
    end else if (|(pulso & cero) && cnt_q != 3'd7) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  assign muerte = (cnt_d >= 3'(N_MUERTE));

  // Next-state logic: death > test > per-state selection rules
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (state_q == ST_MUERTO || muerte) begin
      state_d = ST_MUERTO;
    end else if (Senal_MTest) begin
      state_d = ST_TEST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick.valid) begin
            state_d = ST_ATENDIENDO;
            sel_d   = pick.need;
          end
        end
        ST_ATENDIENDO: begin
          // The chosen need is only re-evaluated on its own 5 s pulse
          if (nivel[sel_q] > UMB) begin
            state_d = ST_IDLE;
          end else if (pulso[sel_q] && pick.valid && nivel[pick.need] < nivel[sel_q]) begin
            sel_d = pick.need;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Test rotation: restarts on entry, advances one slot every T_ROTA cycles
  always_comb begin
    rot_cnt_d = '0;
    slot_d    = 2'd0;
    if (state_q == ST_TEST && state_d == ST_TEST) begin
      if (rot_cnt_q == ROT_LAST) begin
        slot_d = slot_q + 2'd1;
      end else begin
        rot_cnt_d = rot_cnt_q + 1'b1;
        slot_d    = slot_q;
      end
    end
  end

  // Output decode from the next state so the registered outputs track it
  always_comb begin
    activo_d = 4'b0000;
    estado_d = EST_FELIZ;
    alerta_d = hay_cero;
    muerto_d = 1'b0;
    case (state_d)
      ST_ATENDIENDO: begin
        activo_d = 4'b0001 << sel_d;
        estado_d = estado_de(sel_d);
      end
      ST_TEST: begin
        activo_d = 4'b0001 << slot_d;
        estado_d = EST_TEST;
      end
      ST_MUERTO: begin
        estado_d = EST_MUERTO;
        alerta_d = 1'b0;
        muerto_d = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM state and selected need
  always_ff @(posedge clk or negedge B_reset) begin
    // NOTE: non-blocking assignments, so every flop samples pre-edge values.
    if (!B_reset) begin
      state_q <= ST_IDLE;
      sel_q   <= NEED_ENERGIA;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Death and rotation counters
  always_ff @(posedge clk or negedge B_reset) begin
    if (!B_reset) begin
      cnt_q     <= 3'd0;
      rot_cnt_q <= '0;
      slot_q    <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      rot_cnt_q <= rot_cnt_d;
      slot_q    <= slot_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge B_reset) begin
    if (!B_reset) begin
      activo_q <= 4'b0000;
      estado_q <= EST_FELIZ;
      alerta_q <= 1'b0;
      muerto_q <= 1'b0;
    end else begin
      activo_q <= activo_d;
      estado_q <= estado_d;
      alerta_q <= alerta_d;
      muerto_q <= muerto_d;
    end
  end

  assign Activo_Comida   = activo_q[NEED_ENERGIA];
  assign Activo_Medicina = activo_q[NEED_MEDICINA];
  assign Activo_Descanso = activo_q[NEED_DESCANSO];
  assign Activo_Carisia  = activo_q[NEED_ANIMO];
  assign Estado          = estado_q;
  assign Alerta          = alerta_q;
  assign Muerto          = muerto_q;

endmodule

// File: tb/tb_gestor_necesidades.sv
// Testbench for gestor_necesidades: directed stimulus, a behavioural model
// checked on every negedge, plus literal expectations at key points.
module tb_gestor_necesidades;

  localparam int UMBRAL   = 1;
  localparam int N_MUERTE = 4;
  localparam int T_ROTA   = 10;

  // Model states and channel indices (animo, descanso, energia, medicina)
  localparam int S_IDLE = 0;
  localparam int S_ATT  = 1;
  localparam int S_TEST = 2;
  localparam int S_DEAD = 3;

  logic       clk;
  logic       B_reset;
  logic [1:0] Nivel_Animo, Nivel_Descanso, Nivel_Energia, Nivel_Medicina;
  logic       senal_5segAnimo, senal_5segDescanso, senal_5segEnergia, senal_5segMedicina;
  logic       Senal_MTest;
  logic       Activo_Comida, Activo_Medicina, Activo_Descanso, Activo_Carisia;
  logic [2:0] Estado;
  logic       Alerta, Muerto;

  gestor_necesidades #(
    .UMBRAL  (UMBRAL),
    .N_MUERTE(N_MUERTE),
    .T_ROTA  (T_ROTA)
  ) dut (
    .clk               (clk),
    .B_reset           (B_reset),
    .Nivel_Animo       (Nivel_Animo),
    .Nivel_Descanso    (Nivel_Descanso),
    .Nivel_Energia     (Nivel_Energia),
    .Nivel_Medicina    (Nivel_Medicina),
    .senal_5segAnimo   (senal_5segAnimo),
    .senal_5segDescanso(senal_5segDescanso),
    .senal_5segEnergia (senal_5segEnergia),
    .senal_5segMedicina(senal_5segMedicina),
    .Senal_MTest       (Senal_MTest),
    .Activo_Comida     (Activo_Comida),
    .Activo_Medicina   (Activo_Medicina),
    .Activo_Descanso   (Activo_Descanso),
    .Activo_Carisia    (Activo_Carisia),
    .Estado            (Estado),
    .Alerta            (Alerta),
    .Muerto            (Muerto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int         m_state, m_need, m_deaths, m_tcyc;
  int         m_lv[4];
  int         m_p[4];
  logic [3:0] exp_act;
  logic [2:0] exp_est;
  logic       exp_alert, exp_dead;

  // Activo bundle order: {Carisia, Descanso, Medicina, Comida}
  function automatic int act_bit(input int n);
    case (n)
      0:       return 3;  // animo    -> Carisia
      1:       return 2;  // descanso -> Descanso
      2:       return 0;  // energia  -> Comida
      default: return 1;  // medicina -> Medicina
    endcase
  endfunction

  function automatic int est_code(input int n);
    case (n)
      0:       return 4;
      1:       return 3;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  // Lowest critical level; ties resolved medicina, energia, descanso, animo
  function automatic int pick_need();
    int order[4];
    int best;
    order[0] = 3; order[1] = 2; order[2] = 1; order[3] = 0;
    best = -1;
    foreach (order[k]) begin
      if (m_lv[order[k]] <= UMBRAL && (best < 0 || m_lv[order[k]] < m_lv[best]))
        best = order[k];
    end
    return best;
  endfunction

  task automatic model_reset();
    m_state   = S_IDLE;
    m_need    = 0;
    m_deaths  = 0;
    m_tcyc    = 0;
    exp_act   = 4'b0000;
    exp_est   = 3'd0;
    exp_alert = 1'b0;
    exp_dead  = 1'b0;
  endtask

  // One clock of the model, using the inputs present at the rising edge
  task automatic model_step();
    bit any_zero, pulse_zero;
    int best;
    if (!B_reset) return;
    m_lv[0] = int'(Nivel_Animo);   m_p[0] = int'(senal_5segAnimo);
    m_lv[1] = int'(Nivel_Descanso); m_p[1] = int'(senal_5segDescanso);
    m_lv[2] = int'(Nivel_Energia);  m_p[2] = int'(senal_5segEnergia);
    m_lv[3] = int'(Nivel_Medicina); m_p[3] = int'(senal_5segMedicina);
    any_zero = 1'b0;
    pulse_zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_lv[i] == 0) begin
        any_zero = 1'b1;
        if (m_p[i] != 0) pulse_zero = 1'b1;
      end
    end
    if (!any_zero) m_deaths = 0;
    else if (pulse_zero && m_deaths < 7) m_deaths++;
    best = pick_need();
    if (m_state == S_DEAD) begin
      m_state = S_DEAD;
    end else if (m_deaths >= N_MUERTE) begin
      m_state = S_DEAD;
    end else if (Senal_MTest) begin
      if (m_state == S_TEST) m_tcyc++;
      else m_tcyc = 0;
      m_state = S_TEST;
    end else if (m_state == S_TEST) begin
      m_state = S_IDLE;
    end else if (m_state == S_IDLE) begin
      if (best >= 0) begin
        m_state = S_ATT;
        m_need  = best;
      end
    end else begin
      if (m_lv[m_need] > UMBRAL) m_state = S_IDLE;
      else if (m_p[m_need] != 0 && m_lv[best] < m_lv[m_need]) m_need = best;
    end
    exp_act   = 4'b0000;
    exp_est   = 3'd0;
    exp_alert = any_zero;
    exp_dead  = 1'b0;
    case (m_state)
      S_ATT: begin
        exp_act[act_bit(m_need)] = 1'b1;
        exp_est = 3'(est_code(m_need));
      end
      S_TEST: begin
        exp_act[(m_tcyc / T_ROTA) % 4] = 1'b1;
        exp_est = 3'd7;
      end
      S_DEAD: begin
        exp_est   = 3'd5;
        exp_alert = 1'b0;
        exp_dead  = 1'b1;
      end
      default: ;
    endcase
  endtask

  function automatic logic [8:0] dut_bundle();
    return {Activo_Carisia, Activo_Descanso, Activo_Medicina, Activo_Comida,
            Estado, Alerta, Muerto};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: act/est/alerta/muerto got %b_%0d_%b_%b required %b_%0d_%b_%b",
               name, $time, got[8:5], got[4:2], got[1], got[0],
               want[8:5], want[4:2], want[1], want[0]);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] act, input logic [2:0] est,
                     input logic al, input logic mu);
    check(name, dut_bundle(), {act, est, al, mu});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic set_lv(input logic [1:0] a, input logic [1:0] d,
                        input logic [1:0] e, input logic [1:0] m);
    Nivel_Animo = a; Nivel_Descanso = d; Nivel_Energia = e; Nivel_Medicina = m;
  endtask

  // mask order: {animo, descanso, energia, medicina}
  task automatic pulse(input logic [3:0] mask);
    {senal_5segAnimo, senal_5segDescanso, senal_5segEnergia, senal_5segMedicina} = mask;
    tick(1);
    {senal_5segAnimo, senal_5segDescanso, senal_5segEnergia, senal_5segMedicina} = 4'b0000;
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) check("model", dut_bundle(), {exp_act, exp_est, exp_alert, exp_dead});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    B_reset = 1'b1;
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    {senal_5segAnimo, senal_5segDescanso, senal_5segEnergia, senal_5segMedicina} = 4'b0000;
    Senal_MTest = 1'b0;
    model_reset();

    // Reset and quiescent state
    #2 B_reset = 1'b0;
    model_reset();
    #1 lit("reset_async", 4'b0000, 3'd0, 1'b0, 1'b0);
    chk_en = 1'b1;
    @(posedge clk);
    #1 B_reset = 1'b1;
    tick(2);
    lit("idle_all3", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Tie between Energia and Medicina, then chosen need recovers
    set_lv(2'd3, 2'd3, 2'd1, 2'd1);
    tick(1);
    lit("tie_medicina", 4'b0010, 3'd2, 1'b0, 1'b0);
    set_lv(2'd3, 2'd3, 2'd1, 2'd2);
    tick(1);
    lit("recover_idle", 4'b0000, 3'd0, 1'b0, 1'b0);
    tick(1);
    lit("reselect_comida", 4'b0001, 3'd1, 1'b0, 1'b0);
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    tick(2);
    lit("back_idle", 4'b0000, 3'd0, 1'b0, 1'b0);

    // No pre-emption by level alone; own pulse triggers reselection
    set_lv(2'd3, 2'd1, 2'd3, 2'd3);
    tick(1);
    lit("att_descanso", 4'b0100, 3'd3, 1'b0, 1'b0);
    set_lv(2'd0, 2'd1, 2'd3, 2'd3);
    tick(2);
    lit("no_preempt", 4'b0100, 3'd3, 1'b1, 1'b0);
    pulse(4'b0100);
    lit("pulse_switch", 4'b1000, 3'd4, 1'b1, 1'b0);
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    tick(1);
    lit("animo_recovered", 4'b0000, 3'd0, 1'b0, 1'b0);
    tick(1);

    // Death counter cleared by a cycle with no zero level
    set_lv(2'd3, 2'd3, 2'd0, 2'd3);
    tick(1);
    lit("att_energia0", 4'b0001, 3'd1, 1'b1, 1'b0);
    repeat (3) pulse(4'b0010);
    lit("three_pulses", 4'b0001, 3'd1, 1'b1, 1'b0);
    set_lv(2'd3, 2'd3, 2'd2, 2'd3);
    tick(1);
    lit("energia2_idle", 4'b0000, 3'd0, 1'b0, 1'b0);
    set_lv(2'd3, 2'd3, 2'd0, 2'd3);
    pulse(4'b0010);
    lit("cleared_alive", 4'b0001, 3'd1, 1'b1, 1'b0);
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    tick(2);

    // Test mode rotation over 45 cycles, then release
    set_lv(2'd3, 2'd1, 2'd3, 2'd3);
    tick(1);
    Senal_MTest = 1'b1;
    tick(1);
    lit("test_slot0", 4'b0001, 3'd7, 1'b0, 1'b0);
    tick(9);
    lit("test_slot0_end", 4'b0001, 3'd7, 1'b0, 1'b0);
    tick(1);
    lit("test_slot1", 4'b0010, 3'd7, 1'b0, 1'b0);
    tick(10);
    lit("test_slot2", 4'b0100, 3'd7, 1'b0, 1'b0);
    tick(10);
    lit("test_slot3", 4'b1000, 3'd7, 1'b0, 1'b0);
    tick(10);
    lit("test_wrap", 4'b0001, 3'd7, 1'b0, 1'b0);
    tick(4);
    Senal_MTest = 1'b0;
    tick(1);
    lit("test_exit", 4'b0000, 3'd0, 1'b0, 1'b0);
    tick(1);
    lit("test_follow", 4'b0100, 3'd3, 1'b0, 1'b0);
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    tick(2);

    // Death: simultaneous pulses count once, counter runs during test
    set_lv(2'd3, 2'd3, 2'd0, 2'd0);
    tick(1);
    lit("tie_zero_med", 4'b0010, 3'd2, 1'b1, 1'b0);
    pulse(4'b0011);
    lit("dual_pulse", 4'b0010, 3'd2, 1'b1, 1'b0);
    Senal_MTest = 1'b1;
    pulse(4'b0010);
    lit("test_counting", 4'b0001, 3'd7, 1'b1, 1'b0);
    pulse(4'b0001);
    lit("three_alive", 4'b0001, 3'd7, 1'b1, 1'b0);
    Senal_MTest = 1'b0;
    tick(1);
    lit("idle_zero", 4'b0000, 3'd0, 1'b1, 1'b0);
    tick(1);
    lit("att_med_zero", 4'b0010, 3'd2, 1'b1, 1'b0);
    pulse(4'b0010);
    lit("dead", 4'b0000, 3'd5, 1'b0, 1'b1);
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    Senal_MTest = 1'b1;
    tick(3);
    lit("dead_absorbing", 4'b0000, 3'd5, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle
    #2 B_reset = 1'b0;
    model_reset();
    #1 lit("async_clear", 4'b0000, 3'd0, 1'b0, 1'b0);
    tick(1);
    Senal_MTest = 1'b0;
    B_reset = 1'b1;
    tick(2);
    lit("after_reset", 4'b0000, 3'd0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
